load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Data-memory access stage directly downstream of the ALU: takes the ALU result as effective address
//   plus rs2 store data, performs one byte/half/word load or store over a req/ack memory port, and
//   returns the aligned, sign/zero-extended load value. Multi-cycle; the core stalls while o_ready=0.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max REQ cycles awaiting i_memAck before timeout fault; 0 disables the timeout
// PORTS
//   i_clk         in   1   clock, all state on rising edge
//   i_arst_n      in   1   asynchronous active-low reset
//   i_valid       in   1   op request; accepted when i_valid && o_ready
//   o_ready       out  1   1 only in IDLE
//   i_isStore     in   1   1=store, 0=load
//   i_funct3      in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_addr        in   32  effective address (ALU o_result)
//   i_storeData   in   32  rs2 value
//   o_done        out  1   one-cycle completion pulse
//   o_loadData    out  32  extended load result, valid with o_done
//   o_exc         out  2   with o_done: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
//   o_memReq      out  1   memory request, held until ack or timeout
//   o_memWe       out  1   write enable
//   o_memAddr     out  32  word address {addr[31:2],2'b00}
//   o_memBe       out  4   byte enables
//   o_memWdata    out  32  lane-replicated store data
//   i_memAck      in   1   memory done; i_memRdata valid same cycle for loads
//   i_memRdata    in   32  read word
// BEHAVIOUR
//   - Reset: state IDLE; o_ready=1, o_done=0, o_loadData=0, o_exc=00, o_memReq=0, o_memWe=0,
//     o_memAddr=0, o_memBe=0, o_memWdata=0, timeout counter=0. Reset mid-op aborts; o_memReq falls
//     asynchronously; late ack after reset is ignored.
//   - FSM IDLE->REQ->DONE->IDLE; IDLE->DONE directly on fault. Accept captures op, addr, data.
//   - Check at accept: funct3 illegal (load 011/110/111, store >010) -> exc 10; else misaligned
//     (H/HU/SH addr[0]!=0, W/SW addr[1:0]!=0) -> exc 01. Illegal wins. Fault: no memReq, DONE next cycle.
//   - REQ: o_memReq=1, memAddr/memBe/memWe/memWdata stable for whole REQ. Ack may arrive on first
//     REQ cycle. Ack -> DONE next cycle. Latency: accept cycle 0, req cycle 1, ack cycle k>=1, done k+1.
//   - memBe: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111. Loads drive memBe as for stores.
//   - memWdata: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d; loads drive 0.
//   - Load: lane=rdata>>(8*addr[1:0]); B/H sign-extend bit 7/15, BU/HU zero-extend, W passthrough.
//     Captured on ack into o_loadData; stores and faults write o_loadData=0 at DONE.
//   - Timeout: counter increments each REQ cycle without ack; at TIMEOUT_CYCLES drop req, DONE, exc 11.
//     Ack on the same cycle the count is reached wins (normal completion).
//   - DONE: o_done=1 one cycle, o_ready=0; IDLE next cycle. o_loadData/o_exc hold until next DONE.
//   - i_memAck outside REQ ignored. i_valid while o_ready=0 ignored (no queue).
// STRUCTURE
//   - lsu_pkg: funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), exc codes, state_t enum.
//   - Sub-module lsu_load_extend (combinational): {rdata, addr[1:0], funct3} -> 32-bit extended value.
// TESTING
//   - LW addr 0x100, ack cycle 1 rdata 0xDEADBEEF -> memAddr 0x100, memBe 1111, o_done cycle 2, data 0xDEADBEEF.
//   - LB addr 0x103 rdata 0x80FF_1234 -> memBe 1000, o_loadData 0xFFFFFF80; LBU -> 0x00000080.
//   - SH addr 0x22 data 0x0000ABCD -> memWe=1, memAddr 0x20, memBe 1100, memWdata 0xABCDABCD.
//   - LW addr 0x101 -> no memReq, o_done cycle 1, o_exc 01; load funct3 011 -> o_exc 10.
//   - TIMEOUT_CYCLES=4, never ack -> memReq high 4 cycles, o_done with o_exc 11, then o_ready=1.
//   - Assert i_arst_n low mid-REQ, ack on release -> outputs at reset values, no o_done pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, fault codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] EXC_OK      = 2'b00;
    localparam logic [1:0] EXC_MISALGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Byte-lane enables; funct3[1:0] encodes the access size for loads and stores alike.
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3[1:0])
            2'b00:   lsu_byte_en = 4'b0001 << lo;
            2'b01:   lsu_byte_en = 4'b0011 << lo;
            default: lsu_byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_store_rep(input logic [2:0] funct3, input logic [31:0] d);
        case (funct3[1:0])
            2'b00:   lsu_store_rep = {4{d[7:0]}};
            2'b01:   lsu_store_rep = {2{d[15:0]}};
            default: lsu_store_rep = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it to 32 bits.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addrLo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;

    always_comb begin
        lane   = rdata_i >> {addrLo_i, 3'b000};
        data_o = lane;
        case (funct3_i)
            LSU_B:   data_o = {{24{lane[7]}}, lane[7:0]};
            LSU_H:   data_o = {{16{lane[15]}}, lane[15:0]};
            LSU_BU:  data_o = {24'd0, lane[7:0]};
            LSU_HU:  data_o = {16'd0, lane[15:0]};
            LSU_W:   data_o = lane;
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: one byte/half/word load or store per op over a req/ack port,
// with alignment/funct3 checks at accept and an optional request timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_isStore,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_storeData,
    output logic        o_done,
    output logic [31:0] o_loadData,
    output logic [1:0]  o_exc,
    output logic        o_memReq,
    output logic        o_memWe,
    output logic [31:0] o_memAddr,
    output logic [3:0]  o_memBe,
    output logic [31:0] o_memWdata,
    input  logic        i_memAck,
    input  logic [31:0] i_memRdata
);

    state_t      state_q, state_d;
    logic        isStore_q, isStore_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addrLo_q, addrLo_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] loadData_q, loadData_d;
    logic [1:0]  exc_q, exc_d;
    logic        memReq_q, memReq_d;
    logic        memWe_q, memWe_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [3:0]  memBe_q, memBe_d;
    logic [31:0] memWdata_q, memWdata_d;

    logic [31:0] extData;
    logic        illegal, misaligned;

    lsu_load_extend u_ext (
        .rdata_i  (i_memRdata),
        .addrLo_i (addrLo_q),
        .funct3_i (funct3_q),
        .data_o   (extData)
    );

    always_comb begin
        illegal    = i_isStore ? (i_funct3 > LSU_W)
                               : (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);
        misaligned = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                     (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d    = state_q;
        isStore_d  = isStore_q;
        funct3_d   = funct3_q;
        addrLo_d   = addrLo_q;
        cnt_d      = cnt_q;
        loadData_d = loadData_q;
        exc_d      = exc_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memBe_d    = memBe_q;
        memWdata_d = memWdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    isStore_d = i_isStore;
                    funct3_d  = i_funct3;
                    addrLo_d  = i_addr[1:0];
                    cnt_d     = '0;
                    if (illegal || misaligned) begin
                        // Illegal funct3 takes priority; faults skip the memory port entirely.
                        state_d    = ST_DONE;
                        exc_d      = illegal ? EXC_ILLEGAL : EXC_MISALGN;
                        loadData_d = '0;
                    end else begin
                        state_d    = ST_REQ;
                        memReq_d   = 1'b1;
                        memWe_d    = i_isStore;
                        memAddr_d  = {i_addr[31:2], 2'b00};
                        memBe_d    = lsu_byte_en(i_funct3, i_addr[1:0]);
                        memWdata_d = i_isStore ? lsu_store_rep(i_funct3, i_storeData) : '0;
                    end
                end
            end
            ST_REQ: begin
                if (i_memAck) begin
                    state_d    = ST_DONE;
                    memReq_d   = 1'b0;
                    exc_d      = EXC_OK;
                    loadData_d = isStore_q ? '0 : extData;
                end else if (TIMEOUT_CYCLES != 0 && (cnt_q + 32'd1) == TIMEOUT_CYCLES) begin
                    state_d    = ST_DONE;
                    memReq_d   = 1'b0;
                    exc_d      = EXC_TIMEOUT;
                    loadData_d = '0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q    <= ST_IDLE;
            isStore_q  <= 1'b0;
            funct3_q   <= '0;
            addrLo_q   <= '0;
            cnt_q      <= '0;
            loadData_q <= '0;
            exc_q      <= EXC_OK;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memBe_q    <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            isStore_q  <= isStore_d;
            funct3_q   <= funct3_d;
            addrLo_q   <= addrLo_d;
            cnt_q      <= cnt_d;
            loadData_q <= loadData_d;
            exc_q      <= exc_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memBe_q    <= memBe_d;
            memWdata_q <= memWdata_d;
        end
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
    assign o_loadData = loadData_q;
    assign o_exc      = exc_q;
    assign o_memReq   = memReq_q;
    assign o_memWe    = memWe_q;
    assign o_memAddr  = memAddr_q;
    assign o_memBe    = memBe_q;
    assign o_memWdata = memWdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and async reset abort.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        valid, ready, isStore, done, memReq, memWe, memAck;
    logic [2:0]  funct3;
    logic [31:0] addr, storeData, loadData, memAddr, memWdata, memRdata;
    logic [1:0]  exc;
    logic [3:0]  memBe;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk       (clk),
        .i_arst_n    (arst_n),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_isStore   (isStore),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_storeData (storeData),
        .o_done      (done),
        .o_loadData  (loadData),
        .o_exc       (exc),
        .o_memReq    (memReq),
        .o_memWe     (memWe),
        .o_memAddr   (memAddr),
        .o_memBe     (memBe),
        .o_memWdata  (memWdata),
        .i_memAck    (memAck),
        .i_memRdata  (memRdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op for a single accept cycle; returns in cycle 1 with i_valid dropped.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        valid = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = d;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; valid = 1'b0; isStore = 1'b0; funct3 = 3'b000;
        addr = '0; storeData = '0; memAck = 1'b0; memRdata = '0;
        repeat (2) tick();
        chk("rst_ready",    32'(ready),  32'd1);
        chk("rst_done",     32'(done),   32'd0);
        chk("rst_loadData", loadData,    32'd0);
        chk("rst_exc",      32'(exc),    32'd0);
        chk("rst_memReq",   32'(memReq), 32'd0);
        chk("rst_memWe",    32'(memWe),  32'd0);
        chk("rst_memAddr",  memAddr,     32'd0);
        chk("rst_memBe",    32'(memBe),  32'd0);
        chk("rst_memWdata", memWdata,    32'd0);
        arst_n = 1'b1;
        tick();

        // LW 0x100, ack on first REQ cycle
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_req",     32'(memReq), 32'd1);
        chk("lw_we",      32'(memWe),  32'd0);
        chk("lw_addr",    memAddr,     32'h100);
        chk("lw_be",      32'(memBe),  32'hF);
        chk("lw_wdata",   memWdata,    32'h0);
        chk("lw_ready",   32'(ready),  32'd0);
        memAck = 1'b1; memRdata = 32'hDEADBEEF;
        tick();
        memAck = 1'b0;
        chk("lw_done",    32'(done),   32'd1);
        chk("lw_data",    loadData,    32'hDEADBEEF);
        chk("lw_exc",     32'(exc),    32'd0);
        chk("lw_reqdrop", 32'(memReq), 32'd0);
        tick();
        chk("lw_idle",    32'(ready),  32'd1);
        chk("lw_hold",    loadData,    32'hDEADBEEF);

        // LB 0x103 sign-extends the top lane
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_be",   32'(memBe), 32'h8);
        chk("lb_addr", memAddr,    32'h100);
        memAck = 1'b1; memRdata = 32'h80FF_1234;
        tick();
        memAck = 1'b0;
        chk("lb_data", loadData, 32'hFFFFFF80);
        tick();

        // LBU 0x103 zero-extends
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        chk("lbu_data", loadData, 32'h00000080);
        tick();

        // LH 0x102 with ack on the third REQ cycle; the valid seen mid-op must be ignored
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        chk("lh_be", 32'(memBe), 32'hC);
        valid = 1'b1; addr = 32'h500; funct3 = 3'b010;
        tick();
        valid = 1'b0;
        chk("lh_req2",  32'(memReq), 32'd1);
        chk("lh_addr2", memAddr,     32'h100);
        tick();
        memAck = 1'b1; memRdata = 32'h80FF_1234;
        tick();
        memAck = 1'b0;
        chk("lh_done", 32'(done), 32'd1);
        chk("lh_data", loadData,  32'hFFFF80FF);
        tick();

        // LHU 0x102
        issue(1'b0, 3'b101, 32'h102, 32'h0);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        chk("lhu_data", loadData, 32'h000080FF);
        tick();

        // SH 0x22
        issue(1'b1, 3'b001, 32'h22, 32'h0000ABCD);
        chk("sh_we",    32'(memWe), 32'd1);
        chk("sh_addr",  memAddr,    32'h20);
        chk("sh_be",    32'(memBe), 32'hC);
        chk("sh_wdata", memWdata,   32'hABCDABCD);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        chk("sh_done", 32'(done), 32'd1);
        chk("sh_data", loadData,  32'h0);
        chk("sh_exc",  32'(exc),  32'd0);
        tick();

        // SB 0x41
        issue(1'b1, 3'b000, 32'h41, 32'h12345677);
        chk("sb_be",    32'(memBe), 32'h2);
        chk("sb_wdata", memWdata,   32'h77777777);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        tick();

        // Misaligned LW: no request, done next cycle
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        chk("mis_req",  32'(memReq), 32'd0);
        chk("mis_done", 32'(done),   32'd1);
        chk("mis_exc",  32'(exc),    32'd1);
        tick();

        // Illegal load funct3
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        chk("ill_req",  32'(memReq), 32'd0);
        chk("ill_done", 32'(done),   32'd1);
        chk("ill_exc",  32'(exc),    32'd2);
        tick();

        // Illegal store funct3 on a misaligned address: illegal wins
        issue(1'b1, 3'b100, 32'h101, 32'h0);
        chk("illst_exc", 32'(exc), 32'd2);
        tick();

        // Timeout: request held for four cycles, then exc 11
        issue(1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(memReq), 32'd1);
            tick();
        end
        chk("to_reqdrop", 32'(memReq), 32'd0);
        chk("to_done",    32'(done),   32'd1);
        chk("to_exc",     32'(exc),    32'd3);
        chk("to_data",    loadData,    32'd0);
        tick();
        chk("to_ready",   32'(ready),  32'd1);

        // Ack on the cycle the timeout count is reached completes normally
        issue(1'b0, 3'b010, 32'h204, 32'h0);
        repeat (3) tick();
        memAck = 1'b1; memRdata = 32'h0BADF00D;
        tick();
        memAck = 1'b0;
        chk("toack_done", 32'(done), 32'd1);
        chk("toack_exc",  32'(exc),  32'd0);
        chk("toack_data", loadData,  32'h0BADF00D);
        tick();

        // Asynchronous reset mid-REQ, ack arriving on release
        issue(1'b0, 3'b010, 32'h300, 32'h0);
        chk("ar_req", 32'(memReq), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("ar_reqdrop", 32'(memReq), 32'd0);
        chk("ar_ready",   32'(ready),  32'd1);
        tick();
        arst_n = 1'b1; memAck = 1'b1; memRdata = 32'h12345678;
        tick();
        memAck = 1'b0;
        chk("ar_done",     32'(done),   32'd0);
        chk("ar_ready2",   32'(ready),  32'd1);
        chk("ar_memReq",   32'(memReq), 32'd0);
        chk("ar_loadData", loadData,    32'd0);
        chk("ar_exc",      32'(exc),    32'd0);
        chk("ar_memAddr",  memAddr,     32'd0);
        chk("ar_memBe",    32'(memBe),  32'd0);
        tick();
        chk("ar_done2",    32'(done),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
